// File: rtl/n64_vinfo_ext_pkg.sv
// rtl/n64_vinfo_ext_pkg.sv - shared types and defaults for the N64 video-info extractor
package n64_vinfo_ext_pkg;

  typedef enum logic {
    WAIT_VS,
    RUN
  } frame_state_e;

  // Bit positions inside the sync nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  localparam int SYNC_NVSYNC = 3;
  localparam int SYNC_NHSYNC = 1;

  localparam logic [9:0]  PAL_LINE_THRESH_DEF        = 10'd288;
  localparam logic [15:0] DEBLUR_MISMATCH_THRESH_DEF = 16'd16;

  // Field order matches the demux parameter vector, MSB first
  typedef struct packed {
    logic [1:0] data_cnt;
    logic       vmode;
    logic       ndo_deblur;
    logic       n15bit_mode;
  } demuxparams_t;

endpackage

// File: rtl/n64_vinfo_ext_if.sv
// rtl/n64_vinfo_ext_if.sv - N64 digital video bus (nDSYNC + D_i)
interface n64_vinfo_ext_if #(
  parameter int color_width = 7
);
  logic                   nDSYNC;
  logic [color_width-1:0] D_i;

  modport master (output nDSYNC, output D_i);
  modport slave  (input  nDSYNC, input  D_i);
endinterface

// File: rtl/n64_deblur_detect.sv
// rtl/n64_deblur_detect.sv - counts unequal horizontal pixel pairs per frame for auto deblur
module n64_deblur_detect
  import n64_vinfo_ext_pkg::*;
#(
  parameter int          color_width            = 7,
  parameter logic [15:0] DEBLUR_MISMATCH_THRESH = DEBLUR_MISMATCH_THRESH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nDSYNC,
  input  logic [color_width-1:0] D_i,
  input  logic [1:0]             data_cnt,
  input  logic                   hs_neg,
  input  logic                   frame_end,
  output logic                   deblur_req_n
);

  logic [color_width-1:0]   c0, c1;
  logic [3*color_width-1:0] pix, first_pix;
  logic                     pix_done, pair_phase;
  logic [15:0]              cnt;

  assign pix          = {c0, c1, D_i};
  assign deblur_req_n = (cnt >= DEBLUR_MISMATCH_THRESH);

  // pix_done blocks re-completion while data_cnt sits at 11 without a sync nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      c0         <= '0;
      c1         <= '0;
      first_pix  <= '0;
      pix_done   <= 1'b0;
      pair_phase <= 1'b0;
      cnt        <= '0;
    end else if (!nDSYNC) begin
      pix_done <= 1'b0;
      if (hs_neg)    pair_phase <= 1'b0;
      if (frame_end) cnt        <= '0;
    end else begin
      case (data_cnt)
        2'b01: c0 <= D_i;
        2'b10: c1 <= D_i;
        2'b11: begin
          if (!pix_done) begin
            pix_done <= 1'b1;
            if (!pair_phase) begin
              first_pix  <= pix;
              pair_phase <= 1'b1;
            end else begin
              pair_phase <= 1'b0;
              if (pix != first_pix && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/n64_vinfo_ext.sv
// rtl/n64_vinfo_ext.sv - N64 video timing extractor feeding n64_vdemux; N64_AUTODEBLUR_EN adds auto deblur
module n64_vinfo_ext
  import n64_vinfo_ext_pkg::*;
#(
  parameter int          color_width            = 7,
  parameter logic [9:0]  PAL_LINE_THRESH        = PAL_LINE_THRESH_DEF,
  parameter logic [15:0] DEBLUR_MISMATCH_THRESH = DEBLUR_MISMATCH_THRESH_DEF
) (
  input  logic                 VCLK,
  input  logic                 RST,
  n64_vinfo_ext_if.slave       vbus,
  input  logic                 nForceDeBlur_i,
  input  logic                 nAutoDeBlur_i,
  input  logic                 n15bit_mode_i,
  output logic [4:0]           demuxparams_o,
  output logic [1:0]           vinfo_o
);

  demuxparams_t dp;
  frame_state_e state;
  logic [3:0]   sync_prev;
  logic [9:0]   line_cnt;
  logic         field, n64_480i;
  logic         vs_neg, hs_neg, field_bit, n64_480i_next, deblur_req_n;

  assign vs_neg        = !vbus.nDSYNC & sync_prev[SYNC_NVSYNC] & !vbus.D_i[SYNC_NVSYNC];
  assign hs_neg        = !vbus.nDSYNC & sync_prev[SYNC_NHSYNC] & !vbus.D_i[SYNC_NHSYNC];
  assign field_bit     = vbus.D_i[SYNC_NHSYNC];
  assign n64_480i_next = (field_bit != field);

`ifdef N64_AUTODEBLUR_EN
  logic auto_req_n;

  n64_deblur_detect #(
    .color_width           (color_width),
    .DEBLUR_MISMATCH_THRESH(DEBLUR_MISMATCH_THRESH)
  ) u_deblur_detect (
    .clk         (VCLK),
    .rst         (RST),
    .nDSYNC      (vbus.nDSYNC),
    .D_i         (vbus.D_i),
    .data_cnt    (dp.data_cnt),
    .hs_neg      (hs_neg),
    .frame_end   (vs_neg),
    .deblur_req_n(auto_req_n)
  );

  assign deblur_req_n = nAutoDeBlur_i ? nForceDeBlur_i : auto_req_n;
`else
  logic [31:0] unused_cfg;

  assign deblur_req_n = nForceDeBlur_i;
  assign unused_cfg   = color_width ^ 32'(DEBLUR_MISMATCH_THRESH) ^ 32'(vbus.D_i)
                      ^ {31'd0, nAutoDeBlur_i};
`endif

  always_ff @(posedge VCLK) begin
    if (RST) begin
      dp        <= '{data_cnt: 2'b00, vmode: 1'b0, ndo_deblur: 1'b1, n15bit_mode: 1'b0};
      state     <= WAIT_VS;
      sync_prev <= 4'hF;
      line_cnt  <= '0;
      field     <= 1'b0;
      n64_480i  <= 1'b0;
    end else begin
      dp.n15bit_mode <= n15bit_mode_i;

      // data_cnt stays 00 after reset until the first sync nibble re-establishes phase
      if (!vbus.nDSYNC) begin
        sync_prev   <= vbus.D_i[3:0];
        dp.data_cnt <= 2'b01;
      end else if (dp.data_cnt != 2'b00 && dp.data_cnt != 2'b11) begin
        dp.data_cnt <= dp.data_cnt + 2'b01;
      end

      if (vs_neg) begin
        line_cnt <= {9'd0, hs_neg};
        field    <= field_bit;
        state    <= RUN;
        if (state == RUN) begin
          dp.vmode      <= (line_cnt >= PAL_LINE_THRESH);
          n64_480i      <= n64_480i_next;
          dp.ndo_deblur <= n64_480i_next | deblur_req_n;
        end
      end else if (hs_neg && line_cnt != 10'h3FF) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  assign demuxparams_o = dp;
  assign vinfo_o       = {dp.vmode, n64_480i};

endmodule

// File: tb/tb_n64_vinfo_ext.sv
// tb/tb_n64_vinfo_ext.sv - randomized self-checking bench for n64_vinfo_ext
module tb_n64_vinfo_ext;

  logic       clk = 1'b0;
  logic       rst;
  logic       nforce, nauto, n15_in;
  logic [4:0] dp;
  logic [1:0] vinfo;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  n64_vinfo_ext_if #(.color_width(7)) vbus ();

  n64_vinfo_ext #(.color_width(7)) dut (
    .VCLK          (clk),
    .RST           (rst),
    .vbus          (vbus),
    .nForceDeBlur_i(nforce),
    .nAutoDeBlur_i (nauto),
    .n15bit_mode_i (n15_in),
    .demuxparams_o (dp),
    .vinfo_o       (vinfo)
  );

  // Reference model: frame classification from the sync nibbles sent
  logic [3:0] m_prev;
  logic [1:0] m_dcnt;
  int         m_line;
  logic       m_field, m_run, m_vmode, m_480i, m_ndo, m_n15, m_req;

  task automatic model_reset();
    m_prev = 4'hF; m_dcnt = 2'b00; m_line = 0; m_field = 1'b0; m_run = 1'b0;
    m_vmode = 1'b0; m_480i = 1'b0; m_ndo = 1'b1; m_n15 = 1'b0;
  endtask

  function automatic logic [4:0] exp_dp();
    return {m_dcnt, m_vmode, m_ndo, m_n15};
  endfunction

  function automatic logic [2:0] rnd3();
    return 3'($urandom);
  endfunction

  task automatic tick(input logic nd, input logic [6:0] d);
    logic vs, hs, nxt;
    @(negedge clk);
    vbus.nDSYNC = nd;
    vbus.D_i    = d;
    n15_in      = 1'($urandom);
    m_n15       = n15_in;
`ifdef N64_AUTODEBLUR_EN
    if (nauto) m_req = nforce;
`else
    m_req = nforce;
`endif
    if (!nd) begin
      vs = m_prev[3] & !d[3];
      hs = m_prev[1] & !d[1];
      if (vs) begin
        nxt = (d[1] != m_field);
        if (m_run) begin
          m_vmode = (m_line >= 288);
          m_480i  = nxt;
          m_ndo   = nxt | m_req;
        end
        m_field = d[1];
        m_run   = 1'b1;
        m_line  = hs ? 1 : 0;
      end else if (hs && m_line < 1023) begin
        m_line++;
      end
      m_prev = d[3:0];
      m_dcnt = 2'b01;
    end else if (m_dcnt != 2'b00 && m_dcnt != 2'b11) begin
      m_dcnt = m_dcnt + 2'b01;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic [20:0] pa, input logic [20:0] pb);
    tick(1'b0, {rnd3(), 4'hC});
    tick(1'b1, pa[20:14]); tick(1'b1, pa[13:7]); tick(1'b1, pa[6:0]);
    tick(1'b0, {rnd3(), 4'hF});
    tick(1'b1, pb[20:14]); tick(1'b1, pb[13:7]); tick(1'b1, pb[6:0]);
  endtask

  task automatic run_lines(input int n, input int n_uneq);
    logic [20:0] pa;
    for (int i = 0; i < n; i++) begin
      pa = 21'($urandom);
      line(pa, (i < n_uneq) ? (pa ^ 21'h1) : pa);
    end
  endtask

  task automatic vsync(input logic par);
    tick(1'b0, {rnd3(), 1'b0, 1'b1, par, par});
  endtask

  task automatic tail();
    repeat (3) tick(1'b1, 7'd0);
    tick(1'b0, {rnd3(), 4'hF});
    repeat (3) tick(1'b1, 7'd0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    vbus.nDSYNC = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dp !== 5'b00010 || vinfo !== 2'b00)
      $display("FAIL reset_values dp=%b vinfo=%b required dp=00010 vinfo=00", dp, vinfo);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(1'b1, 7'($urandom));
    tick(1'b1, 7'($urandom));
    checks++;
    if (dp !== exp_dp() || vinfo !== 2'b00)
      $display("FAIL reset_no_sync dp=%b required %b vinfo=%b", dp, exp_dp(), vinfo);
    else passed++;
  endtask

  task automatic test_data_phase();
    logic [1:0] want [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    repeat (3) begin
      for (int i = 0; i < 4; i++) begin
        tick((i != 0), (i == 0) ? {rnd3(), 4'hF} : 7'($urandom));
        checks++;
        if (dp[4:3] !== want[i])
          $display("FAIL data_cnt_phase%0d got=%b required=%b", i, dp[4:3], want[i]);
        else passed++;
      end
    end
    repeat (6) begin
      tick(1'b1, 7'($urandom));
      checks++;
      if (dp[4:3] !== 2'b11) $display("FAIL data_cnt_hold got=%b required=11", dp[4:3]);
      else passed++;
    end
    repeat (40) begin
      if ($urandom_range(3) == 0) tick(1'b0, {rnd3(), 4'hF});
      else                        tick(1'b1, 7'($urandom));
      checks++;
      if (dp !== exp_dp()) $display("FAIL data_cnt_random dp=%b required=%b", dp, exp_dp());
      else passed++;
    end
  endtask

  task automatic test_pal_ntsc();
    nforce = 1'b1;
    vsync(1'b1);
    tail();
    repeat (2) begin
      run_lines(263, 0);
      vsync(1'b1);
      checks++;
      if (vinfo[1] !== 1'b0 || dp !== exp_dp() || vinfo !== {m_vmode, m_480i})
        $display("FAIL ntsc_frame vinfo=%b dp=%b required vmode=0 dp=%b", vinfo, dp, exp_dp());
      else passed++;
      tail();
    end
    run_lines(313, 0);
    checks++;
    if (vinfo[1] !== 1'b0) $display("FAIL pal_before_vs vmode=%b required=0", vinfo[1]);
    else passed++;
    vsync(1'b1);
    checks++;
    if (vinfo[1] !== 1'b1 || dp !== exp_dp())
      $display("FAIL pal_frame vinfo=%b dp=%b required vmode=1 dp=%b", vinfo, dp, exp_dp());
    else passed++;
    tail();
  endtask

  task automatic test_480i();
    logic par_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    nforce = 1'b0;
`ifdef N64_AUTODEBLUR_EN
    nauto = 1'b1;
`else
    nauto = 1'($urandom);
`endif
    vsync(1'b1);
    tail();
    for (int f = 0; f < 4; f++) begin
      run_lines(263, 0);
      vsync(par_seq[f]);
      checks++;
      if (dp !== exp_dp() || vinfo !== {m_vmode, m_480i})
        $display("FAIL i480_model f%0d dp=%b vinfo=%b required dp=%b vinfo=%b",
                 f, dp, vinfo, exp_dp(), {m_vmode, m_480i});
      else passed++;
      if (f == 2) begin
        checks++;
        if (vinfo[0] !== 1'b1 || dp[1] !== 1'b1)
          $display("FAIL i480_alternate n64_480i=%b ndo_deblur=%b required 1 1", vinfo[0], dp[1]);
        else passed++;
      end
      if (f == 3) begin
        checks++;
        if (vinfo[0] !== 1'b0 || dp[1] !== 1'b0)
          $display("FAIL i480_constant n64_480i=%b ndo_deblur=%b required 0 0", vinfo[0], dp[1]);
        else passed++;
      end
      tail();
    end
    nauto = 1'b1;
  endtask

  task automatic test_coincident();
    nforce = 1'b1;
    vsync(1'b0);
    tail();
    run_lines(287, 0);
    vsync(1'b1);
    checks++;
    if (vinfo[1] !== 1'b1 || dp !== exp_dp())
      $display("FAIL coincident_288 vmode=%b dp=%b required vmode=1 dp=%b", vinfo[1], dp, exp_dp());
    else passed++;
    tail();
    run_lines(287, 0);
    vsync(1'b1);
    checks++;
    if (vinfo[1] !== 1'b0 || dp !== exp_dp())
      $display("FAIL plain_287 vmode=%b dp=%b required vmode=0 dp=%b", vinfo[1], dp, exp_dp());
    else passed++;
    tail();
  endtask

`ifdef N64_AUTODEBLUR_EN
  task automatic test_auto_deblur();
    nforce = 1'b1;
    nauto  = 1'b0;
    m_req  = 1'b1;
    vsync(1'b1);
    tail();
    run_lines(263, 0);
    m_req = 1'b0;
    vsync(1'b1);
    checks++;
    if (dp[1] !== 1'b0 || dp !== exp_dp())
      $display("FAIL auto_equal ndo_deblur=%b dp=%b required 0 dp=%b", dp[1], dp, exp_dp());
    else passed++;
    tail();
    run_lines(263, 20);
    m_req = 1'b1;
    vsync(1'b1);
    checks++;
    if (dp[1] !== 1'b1 || dp !== exp_dp())
      $display("FAIL auto_unequal ndo_deblur=%b dp=%b required 1 dp=%b", dp[1], dp, exp_dp());
    else passed++;
    tail();
    nauto = 1'b1;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    vbus.nDSYNC = 1'b1;
    vbus.D_i    = '0;
    nforce      = 1'b1;
    nauto       = 1'b1;
    n15_in      = 1'b0;
    model_reset();
    test_reset();
    test_data_phase();
    test_pal_ntsc();
    test_reset();
    test_480i();
    test_coincident();
`ifdef N64_AUTODEBLUR_EN
    test_auto_deblur();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/n64_vinfo_ext.md
# n64_vinfo_ext

Extracts the video timing information from the N64 digital video bus and generates the 5-bit demux parameter vector `{data_cnt, vmode, ndo_deblur, n15bit_mode}` consumed by `n64_vdemux`. It sits directly upstream of the demux and shares its `VCLK`, `nDSYNC` and `D_i`. Per frame, it:
- tracks the RGB data phase;
- classifies PAL/NTSC by line count;
- detects 480i from field parity;
- resolves the deblur decision (forced, or auto-detected when compiled in).

## Interface
Parameters:
- `color_width`, 7: width of `D_i`.
- `PAL_LINE_THRESH`, 10'd288: line count at or above which a frame is PAL.
- `DEBLUR_MISMATCH_THRESH`, 16'd16: auto-deblur mismatch limit per frame.

Ports:
- `VCLK`  in  1  video clock, all logic on rising edge.
- `RST`  in  1  synchronous reset, active-high; sampled on rising `VCLK`.
- `nDSYNC`  in  1  low = sync nibble on `D_i`, high = colour word.
- `D_i`  in  `color_width`  video bus; sync bits `[3:0]` = `{nVSYNC, nCLAMP, nHSYNC, nCSYNC}`.
- `nForceDeBlur_i`  in  1  0 = request deblur; used when auto mode is off or not compiled in.
- `nAutoDeBlur_i`  in  1  0 = use auto detection (only with macro).
- `n15bit_mode_i`  in  1  pass-through to the demux.
- `demuxparams_o`  out  5  `{data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}`.
- `vinfo_o`  out  2  `{vmode, n64_480i}`.

## Operation
- **Sync sampling.** On each edge with `!nDSYNC`, `D_i[3:0]` is stored in `sync_prev`.
  - nVSYNC negedge: `sync_prev[3] & !D_i[3]`.
  - nHSYNC negedge: `sync_prev[1] & !D_i[1]`.
  - Edges are evaluated only on `!nDSYNC` cycles.
- **`data_cnt`.**
  - `!nDSYNC`: loads `2'b01`.
  - Otherwise: increments, saturating at `2'b11`.
  - The demux therefore sees 01/10/11 on the three colour cycles.
- **`line_cnt`.** 10-bit counter, incremented on each nHSYNC negedge, saturating at 1023.
- **Frame end** (nVSYNC negedge):
  - `vmode <= (line_cnt >= PAL_LINE_THRESH)`.
  - `field <= D_i[1]`.
  - `n64_480i <= (D_i[1] != field)`.
  - `line_cnt <=` 1 if an nHSYNC negedge coincides with the nVSYNC negedge, else 0. The decision uses the pre-update count.
- **`ndo_deblur`.** Updated only at frame end.
  - `ndo_deblur <= n64_480i_next | deblur_req_n`.
  - `deblur_req_n` is `nForceDeBlur_i`, or the auto result when auto mode is selected.
- **`n15bit_mode`.** Registered copy of `n15bit_mode_i`, updated every cycle.
- **`demuxparams_o`.** Assembled from the registered fields. It contains no combinational path from any input.
- **`RST`** has priority over all updates. Reset mid-line restarts phase tracking and counting from the next sync nibble.
- **FSM.** No explicit FSM beyond a 2-state frame-validity flag:
  - `WAIT_VS`: entered from reset; suppresses frame-end updates of `vmode`, `n64_480i` and `ndo_deblur`.
  - `RUN`: entered at the first nVSYNC negedge; frame-end updates are enabled from the second nVSYNC negedge on, so the first (partial) frame is never classified.

## Timing
- All outputs are registered; latency is 1 `VCLK` from the sampled event.
- Reset values:
  - `data_cnt` = 00, `vmode` = 0 (NTSC), `n64_480i` = 0, `ndo_deblur` = 1, `n15bit_mode` = 0.
  - `line_cnt` = 0, `field` = 0, `sync_prev` = 4'hF.
- **Classification changes only at frame boundaries.** `vmode`, `n64_480i` and `ndo_deblur` change in the cycle after the nVSYNC-negedge sample. This is the same edge at which the demux latches `n15bit_mode`.
- **Missing `nDSYNC`.** A missing `nDSYNC` low leaves `data_cnt` held at 11, so no extra colour slices are written.

## Configuration
- **`N64_AUTODEBLUR_EN` defined:**
  - Instantiates the pair-mismatch detector and honours `nAutoDeBlur_i`.
  - The detector assembles 21-bit pixels from the three colour cycles. A pair phase, reset at each nHSYNC negedge, compares pixel 2k with 2k+1.
  - A 16-bit saturating counter counts unequal pairs per frame.
  - At frame end it reports `deblur_req_n = (cnt >= DEBLUR_MISMATCH_THRESH)`, then clears the counter.
- **Undefined:** `deblur_req_n = nForceDeBlur_i`; `nAutoDeBlur_i` is ignored.

## Structure
- Add to `vh/n64rgb_params.vh`:
  - `PAL_LINE_THRESH` and `DEBLUR_MISMATCH_THRESH` defaults.
  - Index macros for the `demuxparams` fields (DATA_CNT, VMODE, NDO_DEBLUR, N15BIT).
  - Sync-bit index constants for nVSYNC/nHSYNC.
- Sub-module `n64_deblur_detect`, instantiated only under `N64_AUTODEBLUR_EN`.

## Test plan
1. **Reset.** Assert `RST` 3 cycles → `demuxparams_o = 5'b00010`, `vinfo_o = 2'b00`.
2. **Data phase.** Repeated `nDSYNC` pattern 0,1,1,1 → `data_cnt` reads 01,10,11 on the three high cycles. Also hold `nDSYNC` high for 6 cycles → `data_cnt` stays at 11.
3. **PAL/NTSC.**
   - Frames of 263 nHSYNC negedges → `vmode = 0`.
   - Switch to 313 → `vmode = 1` one cycle after the second frame's nVSYNC negedge; no change before it.
4. **480i.**
   - Alternate `D_i[1]` at successive nVSYNC negedges → `n64_480i = 1` and `ndo_deblur = 1`, even with `nForceDeBlur_i = 0`.
   - Constant parity → `n64_480i = 0`, `ndo_deblur = 0`.
5. **Coincident edges.** nVSYNC and nHSYNC negedge in the same sample → `line_cnt` restarts at 1.
6. **Auto deblur (`N64_AUTODEBLUR_EN`).** With `nAutoDeBlur_i = 0`:
   - Frame with all pairs equal → `ndo_deblur = 0`.
   - Frame with 20 unequal pairs → `ndo_deblur = 1`.
